// File: rtl/dvid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvid_pkg
// Description : Shared DVI-D symbol definitions for the receiver and the
//               transmitter: the four control tokens, the eight data tokens
//               (3-bit pixel values), the channel count, the per-channel
//               alignment state type and a symbol decode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dvid_pkg;

    localparam int c_num_ch = 3;

    // Control tokens, indexed by {c1, c0} (c0 = hsync, c1 = vsync on channel 0)
    localparam logic [9:0] c_ctrl_00 = 10'b1101010100;
    localparam logic [9:0] c_ctrl_01 = 10'b0010101011;
    localparam logic [9:0] c_ctrl_10 = 10'b0101010100;
    localparam logic [9:0] c_ctrl_11 = 10'b1010101011;

    localparam logic [3:0][9:0] c_ctrl_tok = {c_ctrl_11, c_ctrl_10, c_ctrl_01, c_ctrl_00};

    // Data tokens, entry i encodes pixel value i
    localparam logic [7:0][9:0] c_data_tok = {
        10'b1011110000,   // 7
        10'b1000011011,   // 6
        10'b1000111001,   // 5
        10'b0000101111,   // 4
        10'b0010001111,   // 3
        10'b0111001100,   // 2
        10'b0001001111,   // 1
        10'b0111110000    // 0
    };

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_e;

    typedef struct packed {
        logic       valid;
        logic       is_ctrl;
        logic [1:0] ctrl;
        logic [2:0] data;
    } sym_dec_t;

    // Classify a 10-bit word as control token, data token, or invalid.
    function automatic sym_dec_t tmds_decode(input logic [9:0] word);
        sym_dec_t dec;
        dec = '0;
        for (int i = 0; i < 4; i++) begin
            if (word == c_ctrl_tok[i]) begin
                dec.valid   = 1'b1;
                dec.is_ctrl = 1'b1;
                dec.ctrl    = 2'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (word == c_data_tok[i]) begin
                dec.valid = 1'b1;
                dec.data  = 3'(i);
            end
        end
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_ch_align.sv
`default_nettype none
// ============================================================================
// Module      : tmds_ch_align
// Description : One DVI-D channel: keeps the previous raw word, selects a
//               10-bit symbol from the 20-bit window at the current bit
//               offset, decodes it and runs the SEARCH/LOCKED alignment FSM.
// Ports       : clk        - pixel clock (rising edge)
//               rst_n      - asynchronous active-low reset
//               raw_sym    - unaligned word from the deserializer (bit 0 first)
//               locked     - channel is in LOCKED
//               sym_err    - invalid symbol seen while LOCKED (registered)
//               is_ctrl    - last valid symbol was a control token
//               ctrl       - payload of the last control token
//               data       - value of the last data token
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_ch_align
    import dvid_pkg::*;
#(
    parameter int LOCK_COUNT   = 8,
    parameter int SLIP_TIMEOUT = 1024,
    parameter int ERR_LIMIT    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] raw_sym,
    output logic       locked,
    output logic       sym_err,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [2:0] data
);

    localparam int c_run_w = (LOCK_COUNT   > 1) ? $clog2(LOCK_COUNT)   : 1;
    localparam int c_tmo_w = (SLIP_TIMEOUT > 1) ? $clog2(SLIP_TIMEOUT) : 1;
    localparam int c_err_w = (ERR_LIMIT    > 1) ? $clog2(ERR_LIMIT)    : 1;

    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(LOCK_COUNT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(SLIP_TIMEOUT - 1);
    localparam logic [c_err_w-1:0] c_err_last = c_err_w'(ERR_LIMIT - 1);

    align_state_e       state_q,   state_d;
    logic [3:0]         off_q,     off_d;
    logic [c_run_w-1:0] run_q,     run_d;
    logic [c_tmo_w-1:0] tmo_q,     tmo_d;
    logic [c_err_w-1:0] err_cnt_q, err_cnt_d;
    logic [9:0]         prev_q,    prev_d;
    logic               sym_err_q, sym_err_d;
    logic               is_ctrl_q, is_ctrl_d;
    logic [1:0]         ctrl_q,    ctrl_d;
    logic [2:0]         data_q,    data_d;

    logic [19:0] win;
    logic [9:0]  word;
    sym_dec_t    dec;

    always_comb begin
        // Offset 0 selects the previous word; higher offsets pull in the
        // earliest bits of the current word.
        win       = {raw_sym, prev_q};
        word      = win[off_q +: 10];
        dec       = tmds_decode(word);

        state_d   = state_q;
        off_d     = off_q;
        run_d     = run_q;
        tmo_d     = tmo_q;
        err_cnt_d = err_cnt_q;
        prev_d    = raw_sym;
        sym_err_d = 1'b0;
        is_ctrl_d = is_ctrl_q;
        ctrl_d    = ctrl_q;
        data_d    = data_q;

        // Invalid words leave the decoded view untouched.
        if (dec.valid) begin
            is_ctrl_d = dec.is_ctrl;
            if (dec.is_ctrl) begin
                ctrl_d = dec.ctrl;
            end else begin
                data_d = dec.data;
            end
        end

        case (state_q)
            ST_SEARCH: begin
                if (dec.is_ctrl) begin
                    tmo_d = '0;
                    if (run_q == c_run_last) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end else begin
                    run_d = '0;
                    if (tmo_q == c_tmo_last) begin
                        off_d = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
                        tmo_d = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (!dec.valid) begin
                    sym_err_d = 1'b1;
                    if (err_cnt_q == c_err_last) begin
                        // Fall back to searching from the current offset.
                        state_d   = ST_SEARCH;
                        err_cnt_d = '0;
                        run_d     = '0;
                        tmo_d     = '0;
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else begin
                    err_cnt_d = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            off_q     <= '0;
            run_q     <= '0;
            tmo_q     <= '0;
            err_cnt_q <= '0;
            prev_q    <= '0;
            sym_err_q <= 1'b0;
            is_ctrl_q <= 1'b0;
            ctrl_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            run_q     <= run_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
            prev_q    <= prev_d;
            sym_err_q <= sym_err_d;
            is_ctrl_q <= is_ctrl_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
        end
    end

    assign locked  = (state_q == ST_LOCKED);
    assign sym_err = sym_err_q;
    assign is_ctrl = is_ctrl_q;
    assign ctrl    = ctrl_q;
    assign data    = data_q;

endmodule
`default_nettype wire

// File: rtl/dvid_rx.sv
`default_nettype none
// ============================================================================
// Module      : dvid_rx
// Description : Three-channel DVI-D receiver back end. Each channel aligns
//               and decodes independently; this level gates the decoded
//               values by lock/blank state and registers all outputs.
// Ports       : clk, rst_n            - pixel clock, async active-low reset
//               raw_sym0/1/2          - unaligned words for channels 0/1/2
//               hsync, vsync, blank   - channel 0 control decode
//               red, green, blue      - pixel values of channels 0/1/2
//               locked                - per-channel aligned flags
//               sym_err               - invalid symbol on a locked channel
// Revision    : 1.0 - initial release
// ============================================================================
module dvid_rx
    import dvid_pkg::*;
#(
    parameter int LOCK_COUNT   = 8,
    parameter int SLIP_TIMEOUT = 1024,
    parameter int ERR_LIMIT    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] raw_sym0,
    input  logic [9:0] raw_sym1,
    input  logic [9:0] raw_sym2,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [2:0] blue,
    output logic [2:0] locked,
    output logic       sym_err
);

    logic [c_num_ch-1:0][9:0] ch_raw;
    logic [c_num_ch-1:0]      ch_locked;
    logic [c_num_ch-1:0]      ch_err;
    logic [c_num_ch-1:0]      ch_is_ctrl;
    logic [c_num_ch-1:0][1:0] ch_ctrl;
    logic [c_num_ch-1:0][2:0] ch_data;

    assign ch_raw = {raw_sym2, raw_sym1, raw_sym0};

    for (genvar g = 0; g < c_num_ch; g++) begin : g_ch
        tmds_ch_align #(
            .LOCK_COUNT   (LOCK_COUNT),
            .SLIP_TIMEOUT (SLIP_TIMEOUT),
            .ERR_LIMIT    (ERR_LIMIT)
        ) u_align (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_sym (ch_raw[g]),
            .locked  (ch_locked[g]),
            .sym_err (ch_err[g]),
            .is_ctrl (ch_is_ctrl[g]),
            .ctrl    (ch_ctrl[g]),
            .data    (ch_data[g])
        );
    end

    // Control payloads on channels 1 and 2 carry nothing this receiver uses.
    logic unused_ctrl;
    assign unused_ctrl = ^{ch_is_ctrl[2:1], ch_ctrl[2], ch_ctrl[1]};

    logic       hsync_q,   hsync_d;
    logic       vsync_q,   vsync_d;
    logic       blank_q,   blank_d;
    logic [2:0] red_q,     red_d;
    logic [2:0] green_q,   green_d;
    logic [2:0] blue_q,    blue_d;
    logic [2:0] locked_q,  locked_d;
    logic       sym_err_q, sym_err_d;
    logic       active;

    always_comb begin
        // Pixels only pass while channel 0 is aligned and outside blanking.
        active    = ch_locked[0] && !ch_is_ctrl[0];
        blank_d   = !active;
        hsync_d   = ch_locked[0] && ch_ctrl[0][0];
        vsync_d   = ch_locked[0] && ch_ctrl[0][1];
        red_d     = active ? ch_data[0] : 3'd0;
        green_d   = (active && ch_locked[1]) ? ch_data[1] : 3'd0;
        blue_d    = (active && ch_locked[2]) ? ch_data[2] : 3'd0;
        locked_d  = ch_locked;
        sym_err_d = |ch_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            blank_q   <= 1'b1;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            locked_q  <= '0;
            sym_err_q <= 1'b0;
        end else begin
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_q   <= blank_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            locked_q  <= locked_d;
            sym_err_q <= sym_err_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign blank   = blank_q;
    assign red     = red_q;
    assign green   = green_q;
    assign blue    = blue_q;
    assign locked  = locked_q;
    assign sym_err = sym_err_q;

endmodule
`default_nettype wire
